// File: rtl/vending_pkg.sv
// Shared state encoding, coin values and default timing for the change dispenser.
package vending_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_VEND,
      S_PULSE,
      S_GAP,
      S_FIN,
      S_REJ
   } state_t;

   localparam logic [3:0]  MAX_AMOUNT       = 4'd9;
   localparam logic [3:0]  COIN1_VALUE      = 4'd1;
   localparam logic [3:0]  COIN2_VALUE      = 4'd2;
   localparam int unsigned DEF_PULSE_CYCLES = 4;
   localparam int unsigned DEF_GAP_CYCLES   = 2;
   localparam logic [3:0]  DEF_INV_INIT     = 4'd15;
   localparam int unsigned TIMER_W          = 8;

   function automatic logic [3:0] min4(input logic [3:0] a, input logic [3:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; o_tc flags the last cycle of a loaded phase.
module pulse_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_tc
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_tc = (r_count == '0);

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change dispenser: optional item release, then 2-unit coins, then 1-unit coins,
// each actuator pulse followed by an idle gap.
module change_dispense_ctrl
   import vending_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
   parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES,
   parameter logic [3:0]  INV_INIT     = DEF_INV_INIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [3:0] amount,
   input  logic       vend_req,
   input  logic       restock,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       vend_out,
   output logic       chute1,
   output logic       chute2,
   output logic [3:0] inv1,
   output logic [3:0] inv2
);

   localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);

   state_t             r_state;
   state_t             w_state_next;
   logic [3:0]         r_amount;
   logic               r_vend;
   logic [3:0]         r_n1;
   logic [3:0]         r_n2;
   logic [3:0]         r_inv1;
   logic [3:0]         r_inv2;
   logic               r_done;
   logic               r_err;
   logic               r_vend_out;
   logic               r_chute1;
   logic               r_chute2;
   logic [3:0]         w_n2;
   logic [3:0]         w_n1;
   logic               w_reject;
   logic               w_sel2;
   logic               w_load;
   logic [TIMER_W-1:0] w_load_val;
   logic               w_tc;

   pulse_timer #(
      .W (TIMER_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_value (w_load_val),
      .o_tc    (w_tc)
   );

   // Prefer 2-unit coins, limited by stock; the remainder goes out as 1-unit coins.
   assign w_n2     = min4(r_inv2, r_amount / COIN2_VALUE);
   assign w_n1     = (r_amount - w_n2 * COIN2_VALUE) / COIN1_VALUE;
   assign w_reject = (r_amount > MAX_AMOUNT) || (w_n1 > r_inv1);

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_load_val   = PULSE_LOAD;
      w_sel2       = (r_n2 != 4'd0);
      case (r_state)
         S_IDLE: begin
            if (!restock && req) begin
               w_state_next = S_CHECK;
            end
         end
         S_CHECK: begin
            w_sel2 = (w_n2 != 4'd0);
            if (w_reject) begin
               w_state_next = S_REJ;
            end else if (r_vend) begin
               w_state_next = S_VEND;
               w_load       = 1'b1;
            end else if (r_amount != 4'd0) begin
               w_state_next = S_PULSE;
               w_load       = 1'b1;
            end else begin
               w_state_next = S_FIN;
            end
         end
         S_VEND, S_PULSE: begin
            if (w_tc) begin
               w_state_next = S_GAP;
               w_load       = 1'b1;
               w_load_val   = GAP_LOAD;
            end
         end
         S_GAP: begin
            if (w_tc) begin
               if ((r_n1 != 4'd0) || (r_n2 != 4'd0)) begin
                  w_state_next = S_PULSE;
                  w_load       = 1'b1;
               end else begin
                  w_state_next = S_FIN;
               end
            end
         end
         S_FIN, S_REJ: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with it and never glitch.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_vend_out <= 1'b0;
         r_chute1   <= 1'b0;
         r_chute2   <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_done     <= (w_state_next == S_FIN);
         r_err      <= (w_state_next == S_REJ);
         r_vend_out <= (w_state_next == S_VEND);
         r_chute2   <= (w_state_next == S_PULSE) && w_sel2;
         r_chute1   <= (w_state_next == S_PULSE) && !w_sel2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_amount <= 4'd0;
         r_vend   <= 1'b0;
         r_n1     <= 4'd0;
         r_n2     <= 4'd0;
         r_inv1   <= INV_INIT;
         r_inv2   <= INV_INIT;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (restock) begin
                  r_inv1 <= INV_INIT;
                  r_inv2 <= INV_INIT;
               end else if (req) begin
                  r_amount <= amount;
                  r_vend   <= vend_req;
               end
            end
            S_CHECK: begin
               r_n2 <= w_n2;
               r_n1 <= w_n1;
            end
            S_PULSE: begin
               if (w_tc) begin
                  if (r_n2 != 4'd0) begin
                     r_n2 <= r_n2 - 4'd1;
                     if (r_inv2 != 4'd0) begin
                        r_inv2 <= r_inv2 - 4'd1;
                     end
                  end else if (r_n1 != 4'd0) begin
                     r_n1 <= r_n1 - 4'd1;
                     if (r_inv1 != 4'd0) begin
                        r_inv1 <= r_inv1 - 4'd1;
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign err      = r_err;
   assign vend_out = r_vend_out;
   assign chute1   = r_chute1;
   assign chute2   = r_chute2;
   assign inv1     = r_inv1;
   assign inv2     = r_inv2;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed and randomized transactions against a small inventory model; results
// are queued when a request is driven and compared when done/err appears.
module tb_change_dispense_ctrl;

   localparam int P = 4;
   localparam int G = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       req;
   logic [3:0] amount;
   logic       vend_req;
   logic       restock;
   logic       busy;
   logic       done;
   logic       err;
   logic       vend_out;
   logic       chute1;
   logic       chute2;
   logic [3:0] inv1;
   logic [3:0] inv2;

   int n_checks = 0;
   int n_fail   = 0;
   int m_inv1   = 15;
   int m_inv2   = 15;

   typedef struct {
      bit rej;
      int len;
      int nv;
      int n1;
      int n2;
      int inv1;
      int inv2;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   change_dispense_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .amount   (amount),
      .vend_req (vend_req),
      .restock  (restock),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .vend_out (vend_out),
      .chute1   (chute1),
      .chute2   (chute2),
      .inv1     (inv1),
      .inv2     (inv2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic predict(input int amt, input bit v, output exp_t e);
      int n2;
      int n1;
      n2 = amt / 2;
      if (m_inv2 < n2) n2 = m_inv2;
      n1 = amt - 2 * n2;
      e.inv1 = m_inv1;
      e.inv2 = m_inv2;
      if (amt > 9 || n1 > m_inv1) begin
         e.rej = 1'b1;
         e.len = 2;
         e.nv  = 0;
         e.n1  = 0;
         e.n2  = 0;
      end else begin
         e.rej  = 1'b0;
         e.nv   = int'(v);
         e.n1   = n1;
         e.n2   = n2;
         e.len  = 2 + (e.nv + n1 + n2) * (P + G);
         e.inv1 = m_inv1 - n1;
         e.inv2 = m_inv2 - n2;
         m_inv1 = e.inv1;
         m_inv2 = e.inv2;
      end
   endtask

   task automatic do_restock();
      @(negedge clk);
      restock = 1'b1;
      @(negedge clk);
      restock = 1'b0;
      m_inv1 = 15;
      m_inv2 = 15;
      chk("restock_inv1", {28'b0, inv1}, 15);
      chk("restock_inv2", {28'b0, inv2}, 15);
      $display("txn restock -> inv1=%0d inv2=%0d", inv1, inv2);
   endtask

   // Drive one request; inject_at>0 pulses restock+req in that (busy) cycle.
   task automatic run_txn(input int amt, input bit v, input int inject_at);
      exp_t e;
      exp_t got;
      int   cyc;
      int   nv, n1, n2, vrun, c1run, c2run, first_act, order_bad, run1, run2;
      bit   seen1, fin, was_err;
      nv = 0; n1 = 0; n2 = 0; vrun = 0; c1run = 0; c2run = 0;
      first_act = 0; order_bad = 0; seen1 = 1'b0; fin = 1'b0; was_err = 1'b0;
      run1 = m_inv1;
      run2 = m_inv2;
      predict(amt, v, e);
      sb.push_back(e);
      @(negedge clk);
      req      = 1'b1;
      amount   = amt[3:0];
      vend_req = v;
      @(negedge clk);
      req      = 1'b0;
      amount   = 4'($urandom_range(0, 15));
      vend_req = 1'b0;
      cyc = 1;
      while (!fin && cyc < 300) begin
         if (cyc == inject_at) begin
            restock  = 1'b1;
            req      = 1'b1;
            amount   = 4'd1;
            vend_req = 1'b1;
         end else begin
            restock = 1'b0;
            req     = 1'b0;
         end
         chk("actuator_overlap", ($countones({vend_out, chute1, chute2}) > 1) ? 1 : 0, 0);
         chk("busy_in_txn", {31'b0, busy}, 1);
         if ((vend_out || chute1 || chute2) && first_act == 0) first_act = cyc;
         if (vend_out) vrun++;
         else if (vrun > 0) begin
            nv++;
            chk("vend_len", vrun, P);
            vrun = 0;
         end
         if (chute2) begin
            if (c2run == 0 && seen1) order_bad++;
            c2run++;
         end else if (c2run > 0) begin
            n2++;
            run2--;
            chk("chute2_len", c2run, P);
            chk("inv2_step", {28'b0, inv2}, run2);
            c2run = 0;
         end
         if (chute1) begin
            seen1 = 1'b1;
            c1run++;
         end else if (c1run > 0) begin
            n1++;
            run1--;
            chk("chute1_len", c1run, P);
            chk("inv1_step", {28'b0, inv1}, run1);
            c1run = 0;
         end
         if (done || err) begin
            fin     = 1'b1;
            was_err = err;
            chk("done_err_kind", {30'b0, done, err}, e.rej ? 32'd1 : 32'd2);
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      restock = 1'b0;
      req     = 1'b0;
      chk("completed_in_budget", {31'b0, fin}, 1);
      chk("scoreboard_nonempty", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
         got = sb.pop_front();
         chk("reject_flag", {31'b0, was_err}, {31'b0, got.rej});
         chk("txn_length", cyc, got.len);
         chk("vend_pulses", nv, got.nv);
         chk("chute2_pulses", n2, got.n2);
         chk("chute1_pulses", n1, got.n1);
         chk("final_inv1", {28'b0, inv1}, got.inv1);
         chk("final_inv2", {28'b0, inv2}, got.inv2);
         chk("coin_order", order_bad, 0);
         if (got.nv + got.n1 + got.n2 > 0) chk("first_actuator_cycle", first_act, 2);
         else chk("no_actuator", first_act, 0);
      end
      $display("txn amount=%0d vend=%0d -> %s len=%0d vend=%0d c2=%0d c1=%0d inv1=%0d inv2=%0d",
               amt, v, was_err ? "err" : "done", cyc, nv, n2, n1, inv1, inv2);
      @(negedge clk);
      chk("pulse_one_cycle", {29'b0, done, err, busy}, 0);
   endtask

   initial begin
      rst      = 1'b1;
      req      = 1'b0;
      amount   = 4'd0;
      vend_req = 1'b0;
      restock  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {26'b0, busy, done, err, vend_out, chute1, chute2}, 0);
      chk("reset_inv1", {28'b0, inv1}, 15);
      chk("reset_inv2", {28'b0, inv2}, 15);
      rst = 1'b0;

      run_txn(5, 1'b1, 0);

      do_restock();
      for (int i = 0; i < 15; i++) run_txn(1, 1'b0, 0);
      run_txn(3, 1'b0, 0);
      run_txn(10, 1'b0, 0);

      do_restock();
      run_txn(10, 1'b1, 0);
      run_txn(0, 1'b0, 0);
      run_txn(0, 1'b1, 0);
      run_txn(4, 1'b0, 5);
      run_txn(7, 1'b1, 12);

      // Restock wins over a same-cycle request.
      @(negedge clk);
      restock  = 1'b1;
      req      = 1'b1;
      amount   = 4'd5;
      vend_req = 1'b1;
      @(negedge clk);
      restock = 1'b0;
      req     = 1'b0;
      m_inv1  = 15;
      m_inv2  = 15;
      for (int i = 0; i < 3; i++) begin
         chk("restock_req_idle", {28'b0, busy, vend_out, chute1, chute2}, 0);
         @(negedge clk);
      end
      chk("restock_req_inv1", {28'b0, inv1}, 15);
      chk("restock_req_inv2", {28'b0, inv2}, 15);
      $display("txn restock+req -> busy=%0d inv1=%0d inv2=%0d", busy, inv1, inv2);

      // Reset in the middle of the second 2-unit coin pulse.
      @(negedge clk);
      req      = 1'b1;
      amount   = 4'd4;
      vend_req = 1'b0;
      @(negedge clk);
      req = 1'b0;
      repeat (8) @(negedge clk);
      chk("second_chute2_active", {31'b0, chute2}, 1);
      chk("inv2_after_first_coin", {28'b0, inv2}, 14);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_outputs", {26'b0, busy, done, err, vend_out, chute1, chute2}, 0);
      chk("rst_mid_inv1", {28'b0, inv1}, 15);
      chk("rst_mid_inv2", {28'b0, inv2}, 15);
      $display("txn reset mid-pulse -> chute2=%0d inv1=%0d inv2=%0d", chute2, inv1, inv2);
      rst    = 1'b0;
      m_inv1 = 15;
      m_inv2 = 15;
      run_txn(5, 1'b1, 0);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0) do_restock();
         run_txn(int'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), 0);
      end

      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
